// File: rtl/display_pkg.sv
// Shared types and constants for the memory-mapped result display.
package display_pkg;

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam int NUM_HEX_DIGITS = 4;
  localparam int NUM_DEC_DIGITS = 5;
  localparam int CONV_CYCLES    = 16;

  // Active-low {g,f,e,d,c,b,a}, entry 15 first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // One double-dabble step: correct nibbles >= 5, then shift the next bit in.
  function automatic logic [19:0] bcd_step(input logic [19:0] bcd, input logic bit_in);
    logic [19:0] adj;
    adj = bcd;
    for (int i = 0; i < NUM_DEC_DIGITS; i++)
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    return {adj[18:0], bit_in};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to active-low seven-segment pattern.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_TABLE[digit];

endmodule

// File: rtl/result_display.sv
// Captures the I/O result value, converts it to hex or BCD digits and
// multiplexes them onto an 8-digit active-low seven-segment display.
module result_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] result,
  input  logic        dec_mode,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        busy
);

  state_t            state;
  logic [15:0]       cap_val;
  logic              cap_mode;
  logic [15:0]       shift_val;
  logic [19:0]       bcd;
  logic [3:0]        conv_cnt;
  logic [4:0][3:0]   digit;
  logic              disp_mode;
  logic [15:0]       presc;
  logic [2:0]        idx;
  logic [3:0]        cur_digit;
  logic [6:0]        dec_seg;
  logic              active;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cap_val   <= '0;
      cap_mode  <= 1'b0;
      shift_val <= '0;
      bcd       <= '0;
      conv_cnt  <= '0;
      digit     <= '0;
      disp_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: if (result != cap_val || dec_mode != cap_mode) begin
          cap_val   <= result;
          cap_mode  <= dec_mode;
          shift_val <= result;
          bcd       <= '0;
          conv_cnt  <= '0;
          state     <= dec_mode ? CONV : LOAD;
        end
        CONV: begin
          bcd       <= bcd_step(bcd, shift_val[15]);
          shift_val <= {shift_val[14:0], 1'b0};
          conv_cnt  <= conv_cnt + 4'd1;
          if (conv_cnt == 4'(CONV_CYCLES - 1)) state <= LOAD;
        end
        LOAD: begin
          digit     <= cap_mode ? bcd : {4'h0, cap_val};
          disp_mode <= cap_mode;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan mux: only the display registers are read, never the converter.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DEC_DIGITS; i++)
      if (idx == i[2:0]) cur_digit = digit[i];
  end

  assign active = (idx < (disp_mode ? 3'(NUM_DEC_DIGITS) : 3'(NUM_HEX_DIGITS)));

  seg7_decode u_dec (
    .digit (cur_digit),
    .seg_n (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      idx   <= '0;
      an_n  <= 8'hFF;
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
    end else begin
      if (presc == 16'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= idx + 3'd1;
      end else begin
        presc <= presc + 16'd1;
      end
      an_n  <= active ? ~(8'd1 << idx) : 8'hFF;
      seg_n <= active ? dec_seg : 7'h7F;
      dp_n  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_result_display.sv
// Randomized and directed bench for result_display against a per-cycle
// arithmetic model of capture timing, digit values and scan position.
module tb_result_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] result = '0;
  logic        dec_mode = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  result_display #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .reset    (reset),
    .result   (result),
    .dec_mode (dec_mode),
    .seg_n    (seg_n),
    .dp_n     (dp_n),
    .an_n     (an_n),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int pow10 [5] = '{1, 10, 100, 1000, 10000};

  // Model: busy countdown (1 cycle hex, 17 decimal), digits from arithmetic,
  // scan slot from elapsed cycles since reset.
  int         m_cap = 0;
  bit         m_cmode = 0;
  int         m_left = 0;
  int         m_dig [5] = '{0, 0, 0, 0, 0};
  bit         m_dmode = 0;
  int         m_t = 0;
  logic [7:0] e_an = 8'hFF;
  logic [6:0] e_seg = 7'h7F;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int slot, lim;
    if (reset) begin
      m_cap = 0; m_cmode = 0; m_left = 0; m_dmode = 0; m_t = 0;
      for (int k = 0; k < 5; k++) m_dig[k] = 0;
      e_an = 8'hFF; e_seg = 7'h7F;
    end else begin
      slot = (m_t / SD) % 8;
      lim  = m_dmode ? 5 : 4;
      if (slot < lim) begin
        e_an  = 8'(~(8'd1 << slot));
        e_seg = seg_tbl[m_dig[slot]];
      end else begin
        e_an  = 8'hFF;
        e_seg = 7'h7F;
      end
      m_t++;
      if (m_left == 0) begin
        if (int'(result) != m_cap || dec_mode != m_cmode) begin
          m_cap   = int'(result);
          m_cmode = dec_mode;
          m_left  = dec_mode ? 17 : 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          for (int k = 0; k < 5; k++)
            m_dig[k] = m_cmode ? (m_cap / pow10[k]) % 10
                               : (k < 4 ? (m_cap >> (4 * k)) & 15 : 0);
          m_dmode = m_cmode;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy",  {15'd0, busy}, {15'd0, (m_left != 0)});
    chk("an_n",  {8'd0, an_n},  {8'd0, e_an});
    chk("seg_n", {9'd0, seg_n}, {9'd0, e_seg});
    chk("dp_n",  {15'd0, dp_n}, 16'd1);
  endtask

  task automatic busy_len(output int len);
    len = 0;
    tick();
    while (busy && len < 100) begin
      len++;
      tick();
    end
  endtask

  task automatic settle();
    int quiet = 0;
    int k = 0;
    while (quiet < 3 && k < 300) begin
      tick();
      k++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk("settle_timeout", {15'd0, (quiet >= 3)}, 16'd1);
  endtask

  // Watch one full scan rotation and compare per-slot segments to constants.
  task automatic check_display(input string tag, input int ndig, input logic [34:0] exp);
    logic [6:0] got [8];
    int blanks = 0;
    for (int s = 0; s < 8; s++) got[s] = 7'hxx;
    for (int c = 0; c < 8 * SD; c++) begin
      tick();
      if (an_n == 8'hFF) blanks++;
      else for (int s = 0; s < 8; s++)
        if (an_n == 8'(~(8'd1 << s))) got[s] = seg_n;
    end
    for (int s = 0; s < ndig; s++)
      chk($sformatf("%s_slot%0d", tag, s), {9'd0, got[s]}, {9'd0, exp[7*s +: 7]});
    chk({tag, "_blanks"}, 16'(blanks), 16'((8 - ndig) * SD));
  endtask

  initial begin
    int len;
    @(negedge clk);
    tick();
    tick();
    chk("rst_an",   {8'd0, an_n},  16'h00FF);
    chk("rst_seg",  {9'd0, seg_n}, 16'h007F);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    reset = 1'b0;
    check_display("zero", 4, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    result = 16'hBEEF; dec_mode = 1'b0;
    busy_len(len);
    chk("beef_busy_len", 16'(len), 16'd1);
    settle();
    check_display("beef", 4, {7'h40, 7'h03, 7'h06, 7'h06, 7'h0E});

    result = 16'd65535; dec_mode = 1'b1;
    busy_len(len);
    chk("dec_busy_len", 16'(len), 16'd17);
    settle();
    check_display("d65535", 5, {7'h02, 7'h12, 7'h12, 7'h30, 7'h12});

    result = 16'd1234;
    tick();
    repeat (4) tick();
    result = 16'd42;
    settle();
    check_display("d42", 5, {7'h40, 7'h40, 7'h40, 7'h19, 7'h24});

    result = 16'h00FF; dec_mode = 1'b0;
    settle();
    check_display("h00ff", 4, {7'h40, 7'h40, 7'h40, 7'h0E, 7'h0E});
    dec_mode = 1'b1;
    busy_len(len);
    chk("mode_busy_len", 16'(len), 16'd17);
    settle();
    check_display("d255", 5, {7'h40, 7'h40, 7'h24, 7'h12, 7'h12});

    result = 16'd65535;
    tick();
    repeat (7) tick();
    reset = 1'b1; result = '0; dec_mode = 1'b0;
    tick();
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_an",   {8'd0, an_n},  16'h00FF);
    chk("abort_seg",  {9'd0, seg_n}, 16'h007F);
    reset = 1'b0;
    check_display("abort", 4, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) tick();
        reset = 1'b0;
      end
      result   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      dec_mode = 1'($urandom);
      repeat ($urandom_range(1, 30)) tick();
    end
    settle();
    repeat (8 * SD) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 Parameter SCAN_DIV, default 50000: clk cycles per digit scan slot, range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 result  input  16  memory-mapped result value produced by the data-memory I/O port.
REQ-005 dec_mode  input  1  display mode: 1 = decimal, 5 digits; 0 = hex, 4 digits.
REQ-006 seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 dp_n  output  1  decimal point, active-low, registered; always 1.
REQ-008 an_n  output  8  digit enables, active-low one-hot or all-high, registered.
REQ-009 busy  output  1  high while the FSM is not in IDLE.

Function
REQ-010 The block SHALL hold the capture registers cap_val[15:0] and cap_mode, and the display registers digit[0..4][3:0] and disp_mode.
REQ-011 FSM states SHALL be IDLE, CONV and LOAD; busy = (state != IDLE).
REQ-012 In IDLE, if result != cap_val or dec_mode != cap_mode, the block SHALL, at that edge, latch cap_val<=result and cap_mode<=dec_mode, then enter CONV (dec_mode=1) or LOAD (dec_mode=0).
REQ-013 CONV SHALL run a double-dabble of cap_val for exactly 16 cycles, one bit per cycle: add 3 to each 4-bit BCD nibble >=5, then shift left, MSB first; after the 16th cycle it SHALL enter LOAD.
REQ-014 LOAD SHALL last one cycle, write digit[0..4] and disp_mode<=cap_mode, then return to IDLE.
REQ-015 In hex mode, digit[0..3] = cap_val nibbles with digit0 as the LSB nibble, and digit4 = 0; in decimal mode, digit[0..4] = BCD ones..ten-thousands.
REQ-016 Latency from the change cycle N to updated digit registers SHALL be N+2 in hex mode and N+18 in decimal mode.
REQ-017 Changes on result or dec_mode while busy SHALL be ignored, then re-evaluated on return to IDLE, so the final stable input is always displayed.
REQ-018 A 16-bit prescaler SHALL count 0..SCAN_DIV-1 and wrap; on each wrap, the 3-bit scan index SHALL increment modulo 8.
REQ-019 Each cycle, an_n SHALL be registered as ~(1<<index) when index < (disp_mode ? 5 : 4), else 8'hFF.
REQ-020 Each cycle, seg_n SHALL be registered as the decode of digit[index] when index < (disp_mode ? 5 : 4), else 7'h7F.
REQ-021 Decode table: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-022 The scan SHALL run independently of the FSM; digit registers change only in LOAD, so no partially converted value is ever shown.

Reset
REQ-023 On a reset edge, state=IDLE, busy=0, cap_val=0, cap_mode=0, disp_mode=0, all digits=0, prescaler=0, index=0.
REQ-024 On a reset edge, an_n=8'hFF, seg_n=7'h7F, dp_n=1.
REQ-025 Reset asserted mid-CONV or mid-LOAD SHALL abort the operation with no digit update; it has priority over all other events.
REQ-026 After reset release with result=0 and dec_mode=0, no conversion SHALL start.

Structure
REQ-027 Shared package display_pkg SHALL hold the FSM state encoding, the 16-entry segment table, NUM_HEX_DIGITS=4, NUM_DEC_DIGITS=5 and the CONV cycle count 16.
REQ-028 Sub-module seg7_decode (combinational, 4-bit in, 7-bit active-low out) SHALL implement REQ-021; all remaining logic stays in result_display.

Verification (SCAN_DIV=4)
REQ-029 Reset with result=0, dec_mode=0 -> an_n=FF, seg_n=7F, busy=0; after reset, an_n cycles FE,FD,FB,F7,FF,FF,FF,FF with seg_n=40 on enabled slots.
REQ-030 result=16'hBEEF, dec_mode=0 -> busy high exactly 1 cycle; slots 0..3 show seg_n 0E,06,06,03.
REQ-031 result=16'd65535, dec_mode=1 -> busy high exactly 17 cycles; slots 0..4 show 12,30,12,12,02; slots 5..7 show an_n=FF.
REQ-032 result=1234 (dec), then result=42 on the 5th CONV cycle -> 1234 is displayed after its conversion, then a second conversion runs; final digits 2,4,0,0,0 (seg_n 24,19,40,40,40).
REQ-033 result=16'h00FF held, dec_mode 0->1 -> display changes from hex 00FF to decimal 00255 exactly 18 cycles after the mode change.
REQ-034 Reset asserted on the 8th CONV cycle of 65535 -> next edge busy=0 with all reset values; digits stay 0.
